// File: rtl/softmax_ru_pkg.sv
// Shared constants and arithmetic helpers for the softmax reduction unit array.
// Helpers work on 64-bit signed values; callers extend and truncate explicitly.
package softmax_ru_pkg;

  localparam int RU_LAT = 6;

  function automatic int k_one(input int fw);
    return 1 << fw;
  endfunction

  function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b, input int dw);
    return sat_s(a + b, dw);
  endfunction

  function automatic logic signed [63:0] sat_sub(input logic signed [63:0] a,
                                                 input logic signed [63:0] b, input int dw);
    return sat_s(a - b, dw);
  endfunction

  // Arithmetic right shift (floor) followed by saturation to dw bits.
  function automatic logic signed [63:0] sat_asr(input logic signed [63:0] v, input int sh,
                                                 input int dw);
    return sat_s(v >>> sh, dw);
  endfunction

  // Index of the most significant set bit, -1 when v is zero.
  function automatic int lod(input logic [63:0] v);
    int idx;
    idx = -1;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/softmax_ru_lane.sv
// One lane of the softmax reduction datapath: six register stages, all
// enabled by the shared advance signal so every lane moves in lock-step.
module softmax_ru_lane
  import softmax_ru_pkg::*;
#(
  parameter int DW = 16,
  parameter int FW = 10,
  parameter int SW = 32,
  parameter logic [DW-1:0] K_LOG2E = 16'h05C4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  input  logic          sel_mux,
  input  logic          sel_mult,
  input  logic [SW-1:0] in0,
  input  logic [DW-1:0] in1,
  output logic [DW-1:0] out0,
  output logic [DW-1:0] out1
);

  localparam int PW = $clog2(SW);
  localparam logic [63:0] FMASK = (64'd1 << FW) - 64'd1;
  localparam logic [DW-1:0] K_ONE = DW'(k_one(FW));

  logic [SW-1:0]          a1;
  logic signed [DW-1:0]   b1;
  logic [PW-1:0]          p1;
  logic                   zero1;
  logic signed [DW-1:0]   f2;
  logic signed [DW-1:0]   b2;
  logic signed [DW-1:0]   d3;
  logic signed [2*DW-1:0] m4;
  logic signed [DW-1:0]   x5;

  int                     p;
  logic signed [63:0]     frac;
  logic signed [63:0]     lg;
  logic [DW-1:0]          f_next;
  logic signed [DW-1:0]   k_sel;
  int                     e;
  logic [63:0]            mant;
  logic [DW-1:0]          y_next;

  always_comb begin
    p = int'(p1);
    // Fraction is the FW bits just below the leading one, zero-padded when p < FW.
    if (p >= FW) frac = 64'(a1 >> (p - FW));
    else         frac = 64'(a1 << (FW - p));
    frac = frac & FMASK;
    lg = sat_add(64'(p - FW) <<< FW, frac, DW);

    if (sel_mux)    f_next = a1[DW-1:0];
    else if (zero1) f_next = {1'b1, {(DW-1){1'b0}}};
    else            f_next = DW'(lg);

    k_sel = sel_mult ? K_LOG2E : K_ONE;

    // Mitchell pow2: (1.F) shifted by the integer part of x.
    e = int'(x5 >>> FW);
    mant = (64'd1 << FW) | 64'(x5[FW-1:0]);
    if (e > DW - FW - 1) y_next = '1;
    else if (e >= 0)     y_next = DW'(mant << e);
    else                 y_next = DW'(mant >> (-e));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a1    <= '0;
      b1    <= '0;
      p1    <= '0;
      zero1 <= 1'b0;
      f2    <= '0;
      b2    <= '0;
      d3    <= '0;
      m4    <= '0;
      x5    <= '0;
      out0  <= '0;
      out1  <= '0;
    end else if (advance) begin
      a1    <= in0;
      b1    <= in1;
      p1    <= PW'(lod(64'(in0)));
      zero1 <= (in0 == '0);
      f2    <= f_next;
      b2    <= b1;
      d3    <= DW'(sat_sub(64'(b2), 64'(f2), DW));
      m4    <= (2*DW)'(d3) * (2*DW)'(k_sel);
      x5    <= DW'(sat_asr(64'(m4), FW, DW));
      out0  <= x5;
      out1  <= y_next;
    end
  end

endmodule

// File: rtl/softmax_ru_array.sv
// N-lane softmax reduction unit: y = pow2((in1 - f(in0)) * K) per lane,
// six-stage pipeline with valid/ready flow control shared by all lanes.
module softmax_ru_array
  import softmax_ru_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DW = 16,
  parameter int FW = 10,
  parameter int SW = 32,
  parameter logic [DW-1:0] K_LOG2E = 16'h05C4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_sel_mult,
  input  logic                i_sel_mux,
  input  logic [LANES*SW-1:0] i_in0,
  input  logic [LANES*DW-1:0] i_in1,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [LANES*DW-1:0] o_out0,
  output logic [LANES*DW-1:0] o_out1,
  output logic                o_busy
);

  logic [RU_LAT-1:0] vld;
  logic              mux_s1;
  logic [2:0]        mult_s;
  logic              advance;

  // Handshake: a beat transfers on a side when its valid and ready are both high
  // at the clock edge. The whole pipe moves when the output slot is empty or
  // being drained (advance), so o_ready never depends on i_valid.
  assign advance = !o_valid || i_ready;
  assign o_ready = advance;
  assign o_valid = vld[RU_LAT-1];
  assign o_busy  = |vld;

  // Sel bits ride along only as far as the stage that consumes them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld    <= '0;
      mux_s1 <= 1'b0;
      mult_s <= '0;
    end else if (advance) begin
      vld    <= {vld[RU_LAT-2:0], i_valid};
      mux_s1 <= i_sel_mux;
      mult_s <= {mult_s[1:0], i_sel_mult};
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    softmax_ru_lane #(
      .DW(DW),
      .FW(FW),
      .SW(SW),
      .K_LOG2E(K_LOG2E)
    ) u_lane (
      .clk(i_clk),
      .rst(i_rst),
      .advance(advance),
      .sel_mux(mux_s1),
      .sel_mult(mult_s[2]),
      .in0(i_in0[g*SW +: SW]),
      .in1(i_in1[g*DW +: DW]),
      .out0(o_out0[g*DW +: DW]),
      .out1(o_out1[g*DW +: DW])
    );
  end

endmodule

// File: tb/tb_softmax_ru_array.sv
// Directed bench for softmax_ru_array: hand-computed beats go into an expected
// queue and a negedge monitor compares every delivered beat in order.
module tb_softmax_ru_array;

  localparam int LANES = 4;
  localparam int DW = 16;
  localparam int FW = 10;
  localparam int SW = 32;
  localparam int BW = 2 * LANES * DW;

  logic                i_clk;
  logic                i_rst;
  logic                i_valid;
  logic                o_ready;
  logic                i_sel_mult;
  logic                i_sel_mux;
  logic [LANES*SW-1:0] i_in0;
  logic [LANES*DW-1:0] i_in1;
  logic                o_valid;
  logic                i_ready;
  logic [LANES*DW-1:0] o_out0;
  logic [LANES*DW-1:0] o_out1;
  logic                o_busy;

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_q[$];

  logic [15:0] bp_y [10] = '{16'h0400, 16'h0800, 16'h1000, 16'h2000, 16'h4000,
                             16'h8000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};

  softmax_ru_array #(
    .LANES(LANES),
    .DW(DW),
    .FW(FW),
    .SW(SW),
    .K_LOG2E(16'h05C4)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_sel_mult(i_sel_mult),
    .i_sel_mux(i_sel_mux),
    .i_in0(i_in0),
    .i_in1(i_in1),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_out0(o_out0),
    .o_out1(o_out1),
    .o_busy(o_busy)
  );

  // Clock / watchdog
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=still_running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // Checkers
  task automatic check1(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic check32(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic checkv(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Expected-beat builders: {out0 lanes 3..0, out1 lanes 3..0}
  function automatic logic [BW-1:0] beat4(input logic [15:0] x0, input logic [15:0] x1,
                                          input logic [15:0] x2, input logic [15:0] x3,
                                          input logic [15:0] y0, input logic [15:0] y1,
                                          input logic [15:0] y2, input logic [15:0] y3);
    return {x3, x2, x1, x0, y3, y2, y1, y0};
  endfunction

  function automatic logic [BW-1:0] same(input logic [15:0] x, input logic [15:0] y);
    return beat4(x, x, x, x, y, y, y, y);
  endfunction

  // Driver tasks
  task automatic set_lanes(input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] a2, input logic [31:0] a3,
                           input logic [15:0] b0, input logic [15:0] b1,
                           input logic [15:0] b2, input logic [15:0] b3,
                           input logic mux, input logic mult);
    i_in0 = {a3, a2, a1, a0};
    i_in1 = {b3, b2, b1, b0};
    i_sel_mux = mux;
    i_sel_mult = mult;
  endtask

  task automatic set_all(input logic [31:0] a, input logic [15:0] b, input logic mux,
                         input logic mult);
    set_lanes(a, a, a, a, b, b, b, b, mux, mult);
  endtask

  task automatic send_beat(input logic [BW-1:0] e);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    i_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge i_clk);
      acc = o_ready;
      @(posedge i_clk);
      #1;
      n++;
    end
    i_valid = 1'b0;
    if (acc) exp_q.push_back(e);
    else begin
      checks++;
      errors++;
      $error("FAIL accept_timeout: observed=no_accept expected=accept");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    check32("drain", exp_q.size(), 0);
  endtask

  // Scoreboard monitor: a beat leaves on the next posedge when valid & ready.
  always @(negedge i_clk) begin
    if (!i_rst && o_valid && i_ready) begin
      checks++;
      assert (exp_q.size() > 0)
      else begin
        errors++;
        $error("FAIL unexpected_beat: observed=%h expected=none", {o_out0, o_out1});
      end
      if (exp_q.size() > 0) checkv("beat", {o_out0, o_out1}, exp_q.pop_front());
    end
  end

  // Directed sequence
  initial begin
    int n;
    logic [BW-1:0] held;

    i_rst = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_sel_mult = 1'b0;
    i_sel_mux = 1'b0;
    i_in0 = '0;
    i_in1 = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check1("rst_valid", o_valid, 1'b0);
    check1("rst_busy", o_busy, 1'b0);
    checkv("rst_outs", {o_out0, o_out1}, '0);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    check1("ready_after_rst", o_ready, 1'b1);

    // Latency: accepting edge counts as 1, o_valid must appear after the 6th edge.
    set_all(32'h400, 16'h0000, 1'b0, 1'b0);
    send_beat(same(16'h0000, 16'h0400));
    n = 1;
    while (!o_valid && n < 20) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    check32("latency", n, 6);
    drain();

    // Back-to-back directed vectors, all lanes identical
    set_all(32'h400, 16'h0C00, 1'b1, 1'b0);   send_beat(same(16'h0800, 16'h1000));
    set_all(32'h400, 16'h0000, 1'b1, 1'b0);   send_beat(same(16'hFC00, 16'h0200));
    set_all(32'h400, 16'h0800, 1'b1, 1'b1);   send_beat(same(16'h05C4, 16'h0B88));
    set_all(32'h1000, 16'h0000, 1'b0, 1'b0);  send_beat(same(16'hF800, 16'h0100));
    set_all(32'h600, 16'h0000, 1'b0, 1'b0);   send_beat(same(16'hFE00, 16'h0300));
    set_all(32'h0, 16'h8001, 1'b0, 1'b0);     send_beat(same(16'h0001, 16'h0401));
    set_all(32'hFC00, 16'h7C00, 1'b1, 1'b0);  send_beat(same(16'h7FFF, 16'hFFFF));
    set_all(32'h5000, 16'h0000, 1'b1, 1'b0);  send_beat(same(16'hB000, 16'h0000));
    set_all(32'h100, 16'h0000, 1'b0, 1'b0);   send_beat(same(16'h0800, 16'h1000));
    set_all(32'h300, 16'h0000, 1'b0, 1'b0);   send_beat(same(16'h0200, 16'h0600));
    set_all(32'h10000, 16'h0000, 1'b0, 1'b1); send_beat(same(16'hDD68, 16'h0002));
    set_all(32'h1, 16'h0000, 1'b1, 1'b1);     send_beat(same(16'hFFFE, 16'h03FF));
    drain();

    // Independent lanes with alternating sel bits per beat
    set_lanes(32'h400, 32'h400, 32'hFC00, 32'h5000, 16'h0C00, 16'h0000, 16'h7C00, 16'h0000,
              1'b1, 1'b0);
    send_beat(beat4(16'h0800, 16'hFC00, 16'h7FFF, 16'hB000,
                    16'h1000, 16'h0200, 16'hFFFF, 16'h0000));
    set_lanes(32'h400, 32'h10000, 32'h0, 32'h300, 16'h0400, 16'h0000, 16'h8001, 16'h0000,
              1'b0, 1'b1);
    send_beat(beat4(16'h05C4, 16'hDD68, 16'h0001, 16'h02E2,
                    16'h0B88, 16'h0002, 16'h0401, 16'h06E2));
    set_lanes(32'h1, 32'h400, 32'h100, 32'hFC00, 16'h0000, 16'h0800, 16'h0000, 16'h7C00,
              1'b1, 1'b1);
    send_beat(beat4(16'hFFFE, 16'h05C4, 16'hFE8F, 16'h7FFF,
                    16'h03FF, 16'h0B88, 16'h0347, 16'hFFFF));
    set_lanes(32'h1000, 32'h600, 32'h100, 32'h300, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
              1'b0, 1'b0);
    send_beat(beat4(16'hF800, 16'hFE00, 16'h0800, 16'h0200,
                    16'h0100, 16'h0300, 16'h1000, 16'h0600));
    drain();

    // Backpressure: 10 beats streamed, downstream stalls 3 cycles mid-stream
    fork
      begin
        for (int j = 0; j < 10; j++) begin
          set_all(32'h0, 16'(j << 10), 1'b1, 1'b0);
          send_beat(same(16'(j << 10), bp_y[j]));
        end
      end
      begin
        n = 0;
        while (!o_valid && n < 100) begin
          @(posedge i_clk);
          #1;
          n++;
        end
        check1("stall_start_valid", o_valid, 1'b1);
        i_ready = 1'b0;
        @(negedge i_clk);
        held = {o_out0, o_out1};
        check1("stall_ready", o_ready, 1'b0);
        for (int k = 0; k < 2; k++) begin
          @(posedge i_clk);
          #1;
          @(negedge i_clk);
          check1("stall_ready", o_ready, 1'b0);
          check1("stall_valid", o_valid, 1'b1);
          checkv("stall_hold", {o_out0, o_out1}, held);
        end
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight
    set_all(32'h400, 16'h0C00, 1'b1, 1'b0);
    send_beat(same(16'h0800, 16'h1000));
    send_beat(same(16'h0800, 16'h1000));
    send_beat(same(16'h0800, 16'h1000));
    check1("busy_inflight", o_busy, 1'b1);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    exp_q.delete();
    check1("midrst_valid", o_valid, 1'b0);
    check1("midrst_busy", o_busy, 1'b0);
    checkv("midrst_outs", {o_out0, o_out1}, '0);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    check1("midrst_ready", o_ready, 1'b1);
    repeat (12) @(posedge i_clk);
    #1;
    check1("post_rst_busy", o_busy, 1'b0);
    check1("post_rst_valid", o_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
